// File: rtl/multi_issue_queue_pkg.sv
// multi_issue_queue_pkg: shared constants and helpers for the issue queue.
//   IQ_DEPTH / IQ_PUSH_W / IQ_POP_W : default geometry used by the top level.
//   sat_add32                        : 32-bit saturating add for statistics.
package multi_issue_queue_pkg;
   localparam int IQ_DEPTH  = 16;
   localparam int IQ_PUSH_W = 4;
   localparam int IQ_POP_W  = 2;
   localparam int IQ_ELEM_W = 64;

   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction
endpackage

// File: rtl/iq_stats.sv
// iq_stats: saturating occupancy statistics for multi_issue_queue.
// Only compiled when IQ_STATS_EN is defined.
//   clk, rst      : clock, synchronous active-high reset (only rst clears)
//   full_i        : a push group was back-pressured this cycle
//   add_i         : number of entries accepted this cycle
//   full_cycles_o : saturating count of back-pressured cycles
//   pushed_o      : saturating sum of accepted entries
`ifdef IQ_STATS_EN
module iq_stats
   import multi_issue_queue_pkg::*;
#(
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          full_i,
   input  logic [AW-1:0] add_i,
   output logic [31:0]   full_cycles_o,
   output logic [31:0]   pushed_o
);
   logic [31:0] full_q, full_d, pushed_q, pushed_d;

   always_comb begin
      full_d   = sat_add32(full_q, {31'd0, full_i});
      pushed_d = sat_add32(pushed_q, 32'(add_i));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full_q   <= '0;
         pushed_q <= '0;
      end else begin
         full_q   <= full_d;
         pushed_q <= pushed_d;
      end
   end

   assign full_cycles_o = full_q;
   assign pushed_o      = pushed_q;
endmodule
`endif

// File: rtl/multi_issue_queue.sv
// multi_issue_queue: circular issue queue between decode and issue.
// Accepts up to PUSH_W entries per cycle (all-or-nothing) and presents the
// POP_W oldest entries. All outputs come from registered state only.
// Optional macro IQ_STATS_EN adds stat_full_cycles / stat_pushed.
//   clk, rst          : clock, synchronous active-high reset
//   flush             : empty the queue (priority over push/pop)
//   stall             : suppress pops, pushes still allowed
//   in_data/in_number : push lanes, lane 0 oldest, lanes 0..in_number-1 valid
//   pop_number        : entries consumed this cycle
//   iq_size_left      : min(free, PUSH_W);  iq_size : min(count, POP_W)
//   out_data/out_valid: oldest entries, zero / invalid past count
//   err_overflow/err_underflow : sticky protocol errors, cleared by rst only
module multi_issue_queue
   import multi_issue_queue_pkg::*;
#(
   parameter int ELEM_W = IQ_ELEM_W,
   parameter int DEPTH  = IQ_DEPTH,
   parameter int PUSH_W = IQ_PUSH_W,
   parameter int POP_W  = IQ_POP_W,
   parameter int PN     = $clog2(PUSH_W + 1),
   parameter int ON     = $clog2(POP_W + 1)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush,
   input  logic                           stall,
   input  logic [PUSH_W-1:0][ELEM_W-1:0]  in_data,
   input  logic [PN-1:0]                  in_number,
   output logic [PN-1:0]                  iq_size_left,
   output logic [ON-1:0]                  iq_size,
   output logic [POP_W-1:0][ELEM_W-1:0]   out_data,
   output logic [POP_W-1:0]               out_valid,
   input  logic [ON-1:0]                  pop_number,
`ifdef IQ_STATS_EN
   output logic [31:0]                    stat_full_cycles,
   output logic [31:0]                    stat_pushed,
`endif
   output logic                           err_overflow,
   output logic                           err_underflow
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;   // count must reach DEPTH itself

   logic [DEPTH-1:0][ELEM_W-1:0] mem_q;
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d, unf_q, unf_d;

   logic [CW-1:0] free, size_left, size_avail, push_req, pop_req, push_eff, pop_eff;
   logic          push_over, pop_under;

   always_comb begin
      free       = CW'(DEPTH) - count_q;
      size_left  = (free >= CW'(PUSH_W)) ? CW'(PUSH_W) : free;
      size_avail = (count_q >= CW'(POP_W)) ? CW'(POP_W) : count_q;
      push_req   = CW'(in_number);
      pop_req    = CW'(pop_number);
      push_over  = push_req > size_left;
      pop_under  = !stall && (pop_req > size_avail);
      // flush discards this cycle's push, so it never counts as accepted
      push_eff   = (push_over || flush) ? '0 : push_req;
      pop_eff    = stall ? '0 : (pop_under ? size_avail : pop_req);

      head_d  = head_q + PW'(pop_eff);
      tail_d  = tail_q + PW'(push_eff);
      count_d = count_q + push_eff - pop_eff;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
      ovf_d = ovf_q | push_over;
      unf_d = unf_q | pop_under;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Storage has no reset; only slots below count are ever presented.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < PUSH_W; i++) begin
            if (CW'(i) < push_eff) mem_q[tail_q + PW'(i)] <= in_data[i];
         end
      end
   end

   always_comb begin
      out_data  = '0;
      out_valid = '0;
      for (int i = 0; i < POP_W; i++) begin
         if (CW'(i) < count_q) begin
            out_valid[i] = 1'b1;
            out_data[i]  = mem_q[head_q + PW'(i)];
         end
      end
   end

   assign iq_size_left  = PN'(size_left);
   assign iq_size       = ON'(size_avail);
   assign err_overflow  = ovf_q;
   assign err_underflow = unf_q;

`ifdef IQ_STATS_EN
   iq_stats #(.AW(CW)) u_stats (
      .clk           (clk),
      .rst           (rst),
      .full_i        (push_over),
      .add_i         (push_eff),
      .full_cycles_o (stat_full_cycles),
      .pushed_o      (stat_pushed)
   );
`endif
endmodule

// File: tb/tb_multi_issue_queue.sv
// tb_multi_issue_queue: directed self-checking bench for multi_issue_queue
// (DEPTH=16, PUSH_W=4, POP_W=2, ELEM_W=64). Inputs change 1 time unit after
// the rising edge; outputs are checked there, reflecting the state just
// clocked in.
module tb_multi_issue_queue;
   localparam int EW = 64;

   logic clk = 1'b0, rst, flush, stall;
   logic [3:0][EW-1:0] in_data;
   logic [2:0] in_number, iq_size_left;
   logic [1:0] iq_size, out_valid, pop_number;
   logic [1:0][EW-1:0] out_data;
   logic err_overflow, err_underflow;
`ifdef IQ_STATS_EN
   logic [31:0] stat_full_cycles, stat_pushed;
`endif

   int checks = 0, failures = 0;

   multi_issue_queue #(.ELEM_W(EW), .DEPTH(16), .PUSH_W(4), .POP_W(2)) dut (
      .clk(clk), .rst(rst), .flush(flush), .stall(stall),
      .in_data(in_data), .in_number(in_number),
      .iq_size_left(iq_size_left), .iq_size(iq_size),
      .out_data(out_data), .out_valid(out_valid), .pop_number(pop_number),
`ifdef IQ_STATS_EN
      .stat_full_cycles(stat_full_cycles), .stat_pushed(stat_pushed),
`endif
      .err_overflow(err_overflow), .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int n, input logic [EW-1:0] base);
      in_number = 3'(n);
      for (int i = 0; i < 4; i++) in_data[i] = base + EW'(i);
   endtask

   task automatic idle();
      in_number = '0; pop_number = '0; flush = 1'b0; stall = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_data = '0; idle();
      tick(); tick();
      rst = 1'b0;
      chk("rst_size", iq_size, 2'd0);
      chk("rst_left", iq_size_left, 3'd4);
      chk("rst_valid", out_valid, 2'b00);
      chk("rst_data", out_data, '0);
      chk("rst_errs", {err_overflow, err_underflow}, 2'b00);

      // push A..D (0xA0..0xA3)
      push(4, 64'hA0); tick(); idle();
      chk("p4_data", out_data, {64'hA1, 64'hA0});
      chk("p4_valid", out_valid, 2'b11);
      chk("p4_size", iq_size, 2'd2);
      chk("p4_left", iq_size_left, 3'd4);
      pop_number = 2'd2; tick();
      chk("pop_cd", out_data, {64'hA3, 64'hA2});
      tick(); idle();
      chk("empty_valid", out_valid, 2'b00);
      chk("empty_data", out_data, '0);

      // head/tail at 4: advance both to 14
      for (int k = 0; k < 5; k++) begin
         push(2, 64'h10); tick(); idle();
         pop_number = 2'd2; tick(); idle();
      end
      chk("pre_wrap_size", iq_size, 2'd0);

      // entries land at 14,15,0,1
      push(4, 64'hE0); tick(); idle();
      chk("wrap0", {out_valid, out_data}, {2'b11, 64'hE1, 64'hE0});
      pop_number = 2'd2; tick();
      chk("wrap1", {out_valid, out_data}, {2'b11, 64'hE3, 64'hE2});
      tick(); idle();
      chk("wrap_empty", out_valid, 2'b00);
      chk("no_err_yet", {err_overflow, err_underflow}, 2'b00);

      // fill to 14, then a 3-wide push must be dropped
      for (int k = 0; k < 3; k++) begin
         push(4, 64'(64'h100 + 4 * k)); tick();
      end
      push(2, 64'h10C); tick();
      chk("c14_left", iq_size_left, 3'd2);
      push(3, 64'hBAD); tick(); idle();
      chk("ovf_flag", err_overflow, 1'b1);
      chk("ovf_left", iq_size_left, 3'd2);
      chk("ovf_head", out_data, {64'h101, 64'h100});
      push(2, 64'h10E); tick(); idle();
      chk("full_left", iq_size_left, 3'd0);
      chk("full_size", iq_size, 2'd2);

      // flush from full keeps sticky error
      flush = 1'b1; tick(); idle();
      chk("flush_valid", out_valid, 2'b00);
      chk("flush_ovf_sticky", err_overflow, 1'b1);

      // count 8, then flush with concurrent push and pop
      push(4, 64'h200); tick(); push(4, 64'h204); tick(); idle();
      chk("c8_left", iq_size_left, 3'd4);
      flush = 1'b1; push(4, 64'h300); pop_number = 2'd2; tick(); idle();
      chk("fl_valid", out_valid, 2'b00);
      chk("fl_left", iq_size_left, 3'd4);
      chk("fl_size", iq_size, 2'd0);
      chk("fl_data", out_data, '0);

      // count 1: stalled over-pop is silent, unstalled over-pop errors
      push(1, 64'h55); tick(); idle();
      chk("c1_out", {out_valid, out_data}, {2'b01, 64'h0, 64'h55});
      stall = 1'b1; pop_number = 2'd2; tick(); idle();
      chk("stall_size", iq_size, 2'd1);
      chk("stall_unf", err_underflow, 1'b0);
      pop_number = 2'd2; tick(); idle();
      chk("unf_size", iq_size, 2'd0);
      chk("unf_flag", err_underflow, 1'b1);

      rst = 1'b1; tick(); rst = 1'b0;
      chk("rst2_errs", {err_overflow, err_underflow}, 2'b00);
      chk("rst2_left", iq_size_left, 3'd4);

`ifdef IQ_STATS_EN
      chk("st_rst", {stat_full_cycles, stat_pushed}, 64'd0);
      push(4, 64'h400); tick(); push(4, 64'h404); tick(); push(2, 64'h408); tick();
      for (int k = 0; k < 5; k++) begin
         push(5, 64'h500); tick();
      end
      idle();
      chk("st_full", stat_full_cycles, 32'd5);
      chk("st_pushed", stat_pushed, 32'd10);
      flush = 1'b1; tick(); idle();
      chk("st_flush", {stat_full_cycles, stat_pushed}, {32'd5, 32'd10});
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
